// File: rtl/dqs_dly_scan.sv
// DQS output-delay calibration sequencer: sweeps the 5-bit delay tap, drives DQS high then low,
// checks the looped-back level, and programs the centre of the first contiguous passing window.
module dqs_dly_scan #(
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned SAMPLES    = 16,
  parameter logic [4:0]  FAIL_TAP   = 5'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dly_ready,
  input  logic       dqs_received,
  output logic [4:0] dly_data,
  output logic       ld,
  output logic       set,
  output logic       dqs_data,
  output logic       dqs_tri,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [4:0] win_first,
  output logic [4:0] win_last,
  output logic [4:0] best
);

  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, LOAD, SET, SETTLE_HI, MEAS_HI, SETTLE_LO, MEAS_LO,
    EVAL, CLOAD, CSET, CWAIT, DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);

  state_t     state_r, nxt_s;
  logic [7:0] cnt_r;
  logic [4:0] tap_r;
  logic       fail_r, closed_r;
  logic       sync1_r, sync2_r;
  logic       abort_s;
  logic       found_n_s, closed_n_s;
  logic [4:0] first_n_s, last_n_s, best_n_s;
  logic [5:0] sum_s;

  // Window update candidates and next-state selection.
  always_comb begin
    found_n_s  = found;
    closed_n_s = closed_r;
    first_n_s  = win_first;
    last_n_s   = win_last;
    if (!fail_r) begin
      if (!found) begin
        found_n_s = 1'b1;
        first_n_s = tap_r;
        last_n_s  = tap_r;
      end else if (!closed_r) begin
        last_n_s = tap_r;
      end else begin
        last_n_s = win_last;
      end
    end else begin
      if (found) begin
        closed_n_s = 1'b1;
      end else begin
        closed_n_s = closed_r;
      end
    end
    sum_s    = {1'b0, first_n_s} + {1'b0, last_n_s};
    best_n_s = found_n_s ? sum_s[5:1] : FAIL_TAP;

    abort_s = 1'b0;
    if ((state_r == LOAD) || (state_r == SET) || (state_r == SETTLE_HI) ||
        (state_r == MEAS_HI) || (state_r == SETTLE_LO) || (state_r == MEAS_LO)) begin
      abort_s = !dly_ready;
    end else begin
      abort_s = 1'b0;
    end

    nxt_s = state_r;
    case (state_r)
      IDLE:      nxt_s = start ? WAIT_RDY : IDLE;
      WAIT_RDY:  nxt_s = dly_ready ? LOAD : WAIT_RDY;
      LOAD:      nxt_s = abort_s ? WAIT_RDY : SET;
      SET:       nxt_s = abort_s ? WAIT_RDY : SETTLE_HI;
      SETTLE_HI: nxt_s = abort_s ? WAIT_RDY : ((cnt_r == SETTLE_LAST) ? MEAS_HI : SETTLE_HI);
      MEAS_HI:   nxt_s = abort_s ? WAIT_RDY : ((cnt_r == SAMPLE_LAST) ? SETTLE_LO : MEAS_HI);
      SETTLE_LO: nxt_s = abort_s ? WAIT_RDY : ((cnt_r == SETTLE_LAST) ? MEAS_LO : SETTLE_LO);
      MEAS_LO:   nxt_s = abort_s ? WAIT_RDY : ((cnt_r == SAMPLE_LAST) ? EVAL : MEAS_LO);
      EVAL:      nxt_s = (closed_n_s || (tap_r == 5'd31)) ? CLOAD : WAIT_RDY;
      CLOAD:     nxt_s = dly_ready ? CSET : CWAIT;
      CSET:      nxt_s = dly_ready ? DONE : CWAIT;
      CWAIT:     nxt_s = dly_ready ? CLOAD : CWAIT;
      DONE:      nxt_s = IDLE;
      default:   nxt_s = IDLE;
    endcase
  end

  // Two-flop synchronizer on the received pad level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= dqs_received;
      sync2_r <= sync1_r;
    end
  end

  // State register and per-state cycle counter (reloaded on every state change).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= nxt_s;
      cnt_r   <= (nxt_s != state_r) ? 8'd0 : (cnt_r + 8'd1);
    end
  end

  // Tap counter, fail flag and pass-window bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_r     <= 5'd0;
      fail_r    <= 1'b0;
      found     <= 1'b0;
      closed_r  <= 1'b0;
      win_first <= 5'd0;
      win_last  <= 5'd0;
      best      <= 5'd0;
    end else begin
      if (abort_s || ((nxt_s == SETTLE_HI) && (state_r != SETTLE_HI))) begin
        fail_r <= 1'b0;
      end else if ((state_r == MEAS_HI) && (sync2_r != 1'b1)) begin
        fail_r <= 1'b1;
      end else if ((state_r == MEAS_LO) && (sync2_r != 1'b0)) begin
        fail_r <= 1'b1;
      end else begin
        fail_r <= fail_r;
      end

      if ((state_r == IDLE) && start) begin
        tap_r     <= 5'd0;
        found     <= 1'b0;
        closed_r  <= 1'b0;
        win_first <= 5'd0;
        win_last  <= 5'd0;
      end else if (state_r == EVAL) begin
        found     <= found_n_s;
        closed_r  <= closed_n_s;
        win_first <= first_n_s;
        win_last  <= last_n_s;
        if (nxt_s == WAIT_RDY) begin
          tap_r <= tap_r + 5'd1;
        end else begin
          best <= best_n_s;
        end
      end else begin
        tap_r <= tap_r;
      end
    end
  end

  // Registered outputs decoded from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_data <= 5'd0;
      ld       <= 1'b0;
      set      <= 1'b0;
      dqs_data <= 1'b0;
      dqs_tri  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ld       <= (nxt_s == LOAD) || (nxt_s == CLOAD);
      set      <= (nxt_s == SET) || (nxt_s == CSET);
      dqs_data <= (nxt_s == SETTLE_HI) || (nxt_s == MEAS_HI);
      dqs_tri  <= !((nxt_s == SETTLE_HI) || (nxt_s == MEAS_HI) ||
                    (nxt_s == SETTLE_LO) || (nxt_s == MEAS_LO));
      busy     <= (nxt_s != IDLE) && (nxt_s != DONE);
      done     <= (nxt_s == DONE);
      if (nxt_s == LOAD) begin
        dly_data <= tap_r;
      end else if (nxt_s == CLOAD) begin
        dly_data <= (state_r == EVAL) ? best_n_s : best;
      end else begin
        dly_data <= dly_data;
      end
    end
  end

endmodule

// File: doc/dqs_dly_scan.md
Name: dqs_dly_scan

Overview:
- Calibration sequencer for the DQS output-delay test path.
- Steps the 5-bit output delay tap (via the `ld`/`set` load interface) from 0 upward, enables the DQS driver, and checks the received DQS against the driven level.
- Finds the first contiguous run of passing taps and programs its centre.
- Sits between test/control logic and the output-delay/IOBUFDS datapath; clocked on the delay-control clock.

Parameters:
- SETTLE_CYC, 8: cycles waited after each level change before comparing (covers delay, pad and synchronizer latency); range 1..255.
- SAMPLES, 16: compare cycles per level; range 1..255.
- FAIL_TAP, 0: tap loaded at finish when no passing tap is found.

Ports:
- clk  in  1  delay-control clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy.
- dly_ready  in  1  IDELAYCTRL ready.
- dqs_received  in  1  received pad value; passed through an internal 2-flop synchronizer before use.
- dly_data  out  5  tap value presented to the delay load interface.
- ld  out  1  one-cycle load strobe.
- set  out  1  one-cycle apply strobe.
- dqs_data  out  1  level driven on DQS.
- dqs_tri  out  1  1 = driver tristated.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan end.
- found  out  1  at least one passing tap; valid from done until next start.
- win_first  out  5  first passing tap of the run.
- win_last  out  5  last passing tap of the run.
- best  out  5  tap programmed at finish.

Behaviour:
- Reset values: dqs_tri=1. All other outputs 0. State IDLE, tap counter 0.
- States:
  - IDLE: on start → WAIT_RDY. Clear found, first/last, run_closed, tap=0. Set busy.
  - WAIT_RDY: stay until dly_ready=1 → LOAD.
  - LOAD: dly_data=tap, ld=1 for this cycle only → SET.
  - SET: set=1 for this cycle only → SETTLE_HI.
  - SETTLE_HI: dqs_tri=0, dqs_data=1; after SETTLE_CYC cycles → MEAS_HI.
  - MEAS_HI: dqs_data=1; SAMPLES cycles; any synchronized sample ≠ 1 sets fail flag → SETTLE_LO.
  - SETTLE_LO: dqs_data=0; after SETTLE_CYC cycles → MEAS_LO.
  - MEAS_LO: SAMPLES cycles; any sample ≠ 0 sets fail → EVAL.
  - EVAL: dqs_tri=1; update window (rules below), then:
    - if run_closed or tap==31 → CLOAD;
    - else tap+1 → WAIT_RDY.
  - CLOAD / CSET: dly_data=best; ld pulse, then set pulse → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- dqs_tri=0 only in SETTLE_HI/MEAS_HI/SETTLE_LO/MEAS_LO.
- dly_data holds its last value outside the LOAD and CLOAD states.
- Per-tap latency with dly_ready high: 4 + 2·SETTLE_CYC + 2·SAMPLES cycles (52 at defaults).
- Window update in EVAL:
  - pass and !found: found=1, first=last=tap.
  - pass and found and !run_closed: last=tap.
  - fail and found: run_closed=1.
  - fail and !found: no change.
- best = (first+last)>>1, computed with a 6-bit sum (no overflow at 31+31). If !found, best=FAIL_TAP.
- Fail flag clears on entering SETTLE_HI.
- dly_ready falling in any state from LOAD through MEAS_LO: force dqs_tri=1, clear fail flag, → WAIT_RDY. The same tap is retried; the window is unchanged.
- dly_ready low in CLOAD/CSET: → wait, then redo CLOAD once dly_ready=1.
- rst at any time: immediate return to reset values, no done pulse.
- start during busy: ignored. start coincident with rst: rst wins.
- Counters: settle/sample counters are 8 bits, reloaded on each state entry.

Test Plan:
- Loopback model (received=dqs_data for taps 10..20, else stuck 0), dly_ready=1, start → ld/set pulse per tap 0..21. EVAL at tap 21 closes the run. Expect found=1, win_first=10, win_last=20, best=15, one done pulse, final dly_data=15 with ld then set.
- All taps pass → scan reaches 31 → first=0, last=31, best=15 (6-bit sum checked). Expect done exactly 32·52+3 cycles after start at defaults.
- No tap passes (received stuck 1) → found=0, best=FAIL_TAP=0, 32 taps scanned, dqs_tri=1 after done.
- Passing taps only 31 → first=last=31, best=31.
- dly_ready deasserted for 5 cycles during MEAS_HI of tap 12 (pass band 10..20) → dqs_tri=1 immediately, tap 12 reloaded after ready returns, final result unchanged (10/20/15).
- rst asserted mid-MEAS_LO → next cycle all outputs at reset values, no done. A start pulse issued while busy produces no second scan.
